bin2bcd_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bcd_add3_col.sv | 10 +
 rtl/bin2bcd_seq.sv | 115 +++++++++++
 tb/tb_bin2bcd_seq.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// blank/nine digit codes, FSM encoding and the saturation pattern helper.
package bcd_pkg;

  localparam logic [3:0] BCD_BLANK  = 4'hF;
  localparam logic [3:0] BCD_NINE   = 4'h9;
  localparam int         MAX_DIGITS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // All-nines pattern for the lowest 'digits' digits; callers slice to 4*DIGITS bits.
  function automatic logic [4*MAX_DIGITS-1:0] sat_pattern(input int digits);
    logic [4*MAX_DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) r[4*i +: 4] = BCD_NINE;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3_col.sv
// One double-dabble correction column: adds 3 to a BCD digit that is 5 or more.
// A corrected digit never exceeds 4'hF, so no carry leaves the column.
module bcd_add3_col (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with start/done handshake and saturation. Optional macro: BCD_BLANK_EN.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter  int BIN_W  = 14,
  parameter  int DIGITS = 4,
  localparam int CNT_W  = $clog2(BIN_W + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BIN_W-1:0]    value,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                overflow
);

  localparam int AW = 4 * DIGITS;
  localparam logic [4*MAX_DIGITS-1:0] SAT_FULL = sat_pattern(DIGITS);
  localparam logic [AW-1:0]           SAT      = SAT_FULL[AW-1:0];

  state_t           r_state, w_next;
  logic             w_busy;
  logic [BIN_W-1:0] r_sh;
  logic [AW-1:0]    r_acc, w_acc_cor, r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf, r_overflow, r_done;

  // Leading-zero blanking for the display; digit 0 is always shown.
  function automatic logic [AW-1:0] f_present(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = a;
`ifdef BCD_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (lead && (a[4*i +: 4] == 4'd0)) r[4*i +: 4] = BCD_BLANK;
        else                               lead = 1'b0;
      end
    end
`endif
    return r;
  endfunction

  for (genvar g = 0; g < DIGITS; g++) begin : g_col
    bcd_add3_col u_col (
      .i_digit (r_acc[4*g +: 4]),
      .o_digit (w_acc_cor[4*g +: 4])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT: begin
        w_busy = 1'b1;
        if (r_cnt == CNT_W'(1)) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh       <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sh  <= value;
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_cnt <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          // A set MSB after correction would leave the accumulator: value needs more digits.
          {r_acc, r_sh} <= {w_acc_cor[AW-2:0], r_sh, 1'b0};
          r_ovf         <= r_ovf | w_acc_cor[AW-1];
          r_cnt         <= r_cnt - CNT_W'(1);
        end
        DONE: begin
          r_bcd      <= r_ovf ? SAT : f_present(r_acc);
          r_overflow <= r_ovf;
          r_done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = w_busy;
  assign done     = r_done;
  assign bcd      = r_bcd;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized self-checking bench for bin2bcd_seq: default 14-bit/4-digit instance
// plus an exhaustive 8-bit/3-digit instance, both against a decimal reference model.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic [13:0] value0;
  logic [7:0]  value1;
  logic        busy0, busy1, done0, done1, ovf0, ovf1;
  logic [15:0] bcd0;
  logic [11:0] bcd1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .value(value0),
    .busy(busy0), .done(done0), .bcd(bcd0), .overflow(ovf0)
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .value(value1),
    .busy(busy1), .done(done1), .bcd(bcd1), .overflow(ovf1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decimal digits by division, saturated when value does not fit in d digits.
  function automatic logic [63:0] ref_bcd(input int v, input int d);
    logic [63:0] r;
    int          x;
    r = '0;
    if (v >= 10 ** d) begin
      for (int i = 0; i < d; i++) r[4*i +: 4] = 4'h9;
      return r;
    end
    x = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef BCD_BLANK_EN
    begin
      bit lead;
      lead = 1'b1;
      for (int i = d - 1; i >= 1; i--) begin
        if (lead && r[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'hF;
        else                             lead = 1'b0;
      end
    end
`endif
    return r;
  endfunction

  // One conversion on instance sel; returns result, latency from accepting edge, busy cycles.
  task automatic convert(input bit sel, input int v, output logic [63:0] b, output bit o,
                         output int lat, output int bcnt);
    if (sel) begin start1 = 1'b1; value1 = 8'(v);  end
    else     begin start0 = 1'b1; value0 = 14'(v); end
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    value0 = 14'($urandom); value1 = 8'($urandom);
    bcnt = sel ? int'(busy1) : int'(busy0);
    lat  = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      lat++;
      if (sel ? done1 : done0) break;
      bcnt += sel ? int'(busy1) : int'(busy0);
    end
    b = sel ? 64'(bcd1) : 64'(bcd0);
    o = sel ? ovf1 : ovf0;
  endtask

  initial begin
    logic [63:0] b;
    bit          o;
    int          lat, bcnt, ndone;
    logic [63:0] held;
    int          vals[$];

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; value0 = '0; value1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_done", 64'(done0), 64'd0);
    check("rst_bcd",  64'(bcd0),  64'd0);
    check("rst_ovf",  64'(ovf0),  64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    vals = '{1234, 9999, 10000, 16383, 0, 305, 1, 9, 10, 99, 1000};
    for (int i = 0; i < 20; i++) vals.push_back(int'($urandom_range(0, 16383)));
    foreach (vals[i]) begin
      convert(1'b0, vals[i], b, o, lat, bcnt);
      check($sformatf("bcd_%0d", vals[i]), b, ref_bcd(vals[i], 4));
      check($sformatf("ovf_%0d", vals[i]), 64'(o), 64'(vals[i] >= 10000));
      check("latency", 64'(lat), 64'd15);
      check("busy_cycles", 64'(bcnt), 64'd14);
      held = b;
      @(posedge clk); #1;
      check("done_one_pulse", 64'(done0), 64'd0);
      check("bcd_held", 64'(bcd0), held);
    end

    // Second start 3 cycles into a conversion must be ignored.
    start0 = 1'b1; value0 = 14'd1234;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start0 = 1'b1; value0 = 14'd42;
    @(posedge clk); #1;
    start0 = 1'b0;
    ndone = 0; held = '0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done0) begin ndone++; held = 64'(bcd0); end
    end
    check("retrig_done_count", 64'(ndone), 64'd1);
    check("retrig_bcd", held, ref_bcd(1234, 4));

    // Reset mid-conversion aborts without a done pulse.
    start0 = 1'b1; value0 = 14'd1234;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_bcd",  64'(bcd0),  64'd0);
    check("abort_ovf",  64'(ovf0),  64'd0);
    check("abort_busy", 64'(busy0), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done0) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    convert(1'b0, 7, b, o, lat, bcnt);
    check("after_abort_bcd", b, ref_bcd(7, 4));
    check("after_abort_lat", 64'(lat), 64'd15);

    // Exhaustive sweep of the 8-bit/3-digit instance.
    for (int v = 0; v < 256; v++) begin
      convert(1'b1, v, b, o, lat, bcnt);
      check($sformatf("sw_bcd_%0d", v), b, ref_bcd(v, 3));
      check($sformatf("sw_ovf_%0d", v), 64'(o), 64'd0);
      check("sw_latency", 64'(lat), 64'd9);
      if (v % 64 == 0) check("sw_busy_cycles", 64'(bcnt), 64'd8);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
